// File: rtl/riscv_pkg.sv
// Shared RV32I definitions used by the core and its trace capture logic.
// Holds the retirement trace record format and its classification helper.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        KIND_NONE  = 2'd0,
        KIND_REG   = 2'd1,
        KIND_STORE = 2'd2
    } trace_kind_e;

    typedef struct packed {
        trace_kind_e       kind;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   instr;
        logic [4:0]        rd_addr;
        logic [XLEN-1:0]   rd_data;
        logic [XLEN-1:0]   mem_addr;
        logic [XLEN-1:0]   mem_data;
    } trace_rec_t;

    // A register write takes priority over a store when both are flagged.
    function automatic trace_kind_e classify_kind(input logic [4:0] rd_addr, input logic mem_wrt);
        if (rd_addr != 5'd0) begin
            return KIND_REG;
        end else if (mem_wrt) begin
            return KIND_STORE;
        end else begin
            return KIND_NONE;
        end
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Generic synchronous FIFO with separate occupancy count.
// Push while full is accepted only when a pop frees the head slot in the same cycle.
module trace_fifo #(
    parameter int  DEPTH = 16,
    parameter type T     = logic,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  T              wdata,
    input  logic          pop,
    output T              rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    T              mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == CW'(0));
    assign count     = count_r;
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);
    assign rdata     = empty ? T'('0) : mem_r[rd_ptr_r];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; when full with push+pop the tail aliases the head being popped.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

endmodule

// File: rtl/commit_trace_buffer.sv
// Retirement trace capture: filters write-back commits, classifies them and queues
// records for a valid/ready consumer, counting drops instead of stalling the core.
module commit_trace_buffer
    import riscv_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     commit_i,
    input  logic                     stall_i,
    input  logic [XLEN-1:0]          pc_i,
    input  logic [XLEN-1:0]          instr_i,
    input  logic [4:0]               rd_addr_i,
    input  logic [XLEN-1:0]          rd_data_i,
    input  logic                     mem_wrt_i,
    input  logic [XLEN-1:0]          mem_addr_i,
    input  logic [XLEN-1:0]          mem_data_i,
    output logic                     trace_valid_o,
    input  logic                     trace_ready_i,
    output trace_rec_t               trace_rec_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o,
    output logic [CNT_W-1:0]         drop_cnt_o,
    input  logic                     clr_i
);

    logic       cap_s;
    logic       pop_s;
    logic       full_s;
    logic       empty_s;
    logic       drop_s;
    trace_rec_t rec_s;
    logic       overflow_r;
    logic [CNT_W-1:0] drop_cnt_r;

    // A zero instruction word marks a flushed bubble; stalled cycles repeat the same retirement.
    assign cap_s  = commit_i && (instr_i != XLEN'(0)) && !stall_i;
    assign pop_s  = !empty_s && trace_ready_i;
    assign drop_s = cap_s && full_s && !pop_s;

    // Record assembly with fields irrelevant to the kind forced to zero.
    always_comb begin
        rec_s         = '0;
        rec_s.kind    = classify_kind(rd_addr_i, mem_wrt_i);
        rec_s.pc      = pc_i;
        rec_s.instr   = instr_i;
        rec_s.rd_addr = rd_addr_i;
        case (rec_s.kind)
            KIND_REG: begin
                rec_s.rd_data = rd_data_i;
            end
            KIND_STORE: begin
                rec_s.mem_addr = mem_addr_i;
                rec_s.mem_data = mem_data_i;
            end
            default: begin
                rec_s.rd_data = XLEN'(0);
            end
        endcase
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .T     (trace_rec_t)
    ) u_fifo (
        .clk   (clk_i),
        .rst_n (rstn_i),
        .push  (cap_s),
        .wdata (rec_s),
        .pop   (pop_s),
        .rdata (trace_rec_o),
        .full  (full_s),
        .empty (empty_s),
        .count (count_o)
    );

    assign trace_valid_o = !empty_s;

    // Sticky overflow flag and saturating drop counter; a same-cycle drop wins over clear.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            overflow_r <= 1'b0;
            drop_cnt_r <= CNT_W'(0);
        end else if (clr_i) begin
            overflow_r <= drop_s;
            drop_cnt_r <= drop_s ? CNT_W'(1) : CNT_W'(0);
        end else if (drop_s) begin
            overflow_r <= 1'b1;
            drop_cnt_r <= (drop_cnt_r == {CNT_W{1'b1}}) ? drop_cnt_r : drop_cnt_r + CNT_W'(1);
        end else begin
            overflow_r <= overflow_r;
            drop_cnt_r <= drop_cnt_r;
        end
    end

    assign overflow_o = overflow_r;
    assign drop_cnt_o = drop_cnt_r;

endmodule
